nx_indirect_access_initiator: RTL
=================================

// Module: nx_indirect_access_initiator
// PURPOSE
//  Master-side sequencer for the indirect register-array access protocol.
//  Accepts one entry-level request (read/write, entry index, data) from a local agent.
//  Converts it into CSR-bus transactions to the target block:
//   - data register write (write op only)
//   - command register write
//   - status register polls until not busy
//   - data register read (read op only)
//  Returns the final status code and any read data. Sits between the config/test
//  agent and any indirect-access register array.
// PARAMETERS
//  CMND_ADDRESS  11'h454  CSR address of target command register
//  STAT_ADDRESS  11'h44C  CSR address of target status register
//  DATA_ADDRESS  11'h450  CSR address of target data register (one 32b word)
//  N_ENTRY_BITS  5        width of entry index
//  POLL_MAX      16       maximum status reads before timeout (>=1)
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   initiator idle, request accepted when valid&ready
//  req_op       in   4   4'h0 WR, 4'h1 RD; others forwarded unchanged
//  req_addr     in   N_ENTRY_BITS  entry index
//  req_wdat     in   32  write data (WR only)
//  rsp_valid    out  1   one-cycle pulse, response complete
//  rsp_code     out  3   final status code (see BEHAVIOUR)
//  rsp_rdat     out  32  read data (RD with code RDY), else 0
//  csr_addr     out  11  CSR address
//  csr_wr_stb   out  1   one-cycle write strobe
//  csr_rd_stb   out  1   one-cycle read strobe
//  csr_wr_dat   out  32  CSR write data
//  csr_ack      in   1   target acknowledge, one per strobe, >=1 cycle after it
//  csr_rd_dat   in   32  read data, valid when csr_ack follows csr_rd_stb
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (reset).
//  Reset values: req_ready=1 (from the first cycle after reset), rsp_valid=0, rsp_code=0,
//   rsp_rdat=0, csr_addr=0, csr_wr_stb=0, csr_rd_stb=0, csr_wr_dat=0.
//  Reset mid-operation: abandon the transaction, return to IDLE, suppress rsp_valid.
//   A late csr_ack after reset is ignored.
//  Command word: {req_op[3:0], 28'b0} | req_addr, with the index in bits [N_ENTRY_BITS-1:0].
//  Status word: code = csr_rd_dat[31:29]. 0 RDY, 1 BSY, 2 ERR_CMD, 3 ERR_ADDR;
//   others treated as error and passed through. Internal code 3'd7 TIMEOUT.
//  CSR rules:
//   - At most one outstanding strobe.
//   - Strobe is high exactly one cycle. csr_addr/csr_wr_dat are held until ack.
//   - The next strobe issues no earlier than the cycle after ack.
//  FSM: IDLE -> [WR_DATA] -> WR_CMND -> POLL -> [RD_DATA] -> RESP -> IDLE.
//   IDLE:    req_ready=1. On accept, latch op/addr/wdat. Go to WR_DATA if op==WR,
//            else WR_CMND. The next cycle drives the strobe.
//   WR_DATA: write req_wdat to DATA_ADDRESS; on ack -> WR_CMND.
//   WR_CMND: write command word to CMND_ADDRESS; on ack -> POLL with poll_cnt=0.
//   POLL:    read STAT_ADDRESS; on ack poll_cnt++.
//            code==BSY and poll_cnt<POLL_MAX: re-poll.
//            code==BSY and poll_cnt==POLL_MAX: rsp_code=7 -> RESP.
//            code==RDY and op==RD: -> RD_DATA.
//            otherwise: rsp_code=code -> RESP.
//   RD_DATA: read DATA_ADDRESS; on ack rsp_rdat=csr_rd_dat, rsp_code=RDY -> RESP.
//   RESP:    rsp_valid=1 for one cycle -> IDLE. rsp_code/rsp_rdat hold until the next response.
//  req_ready is 0 from the accept cycle through RESP. A back-to-back request is accepted
//   the cycle after RESP.
//  rsp_rdat is zeroed at accept.
//  poll_cnt width is $clog2(POLL_MAX+1) and never wraps.
//  Unsolicited csr_ack (no outstanding strobe) is ignored.
//  Minimum latency, accept to rsp_valid, zero-wait target (ack the cycle after strobe):
//   WR = 7 cycles, RD = 7 cycles with a single poll.
// TESTING
//  WR op=0 addr=5 wdat=32'hDEADBEEF, 1-cycle ack, first poll RDY
//   -> CSR writes 0x450=DEADBEEF, 0x454=0x00000005; one read of 0x44C;
//      rsp_valid with code 0, rdat 0.
//  RD addr=31; status BSY twice then RDY; data read returns 32'hA5A5_0001
//   -> three status reads, one data read; rsp_code 0, rsp_rdat A5A50001.
//  RD; status always BSY (POLL_MAX=16)
//   -> exactly 16 status reads, rsp_code 7, no data read.
//  op=4'h3; status returns code 2
//   -> no data write, command word 0x30000000|addr; rsp_code 2, rsp_rdat 0.
//  Reset asserted during POLL with an ack arriving 2 cycles later
//   -> no rsp_valid, outputs at reset values, req_ready=1; the ack is ignored.
//  Two back-to-back requests with 5-cycle ack latency
//   -> strobes never overlap, second accepted the cycle after the first rsp_valid.

Source files
------------

// File: rtl/nx_indirect_access_initiator.sv
// -----------------------------------------------------------------------------
// nx_indirect_access_initiator
//
// Master-side sequencer for the indirect register-array access protocol.
// One entry-level request from a local agent is turned into a short series of
// CSR-bus transactions towards the target block:
//   data register write (WR only) -> command register write ->
//   status register polls until not busy -> data register read (RD, RDY only)
// The final status code and any read data are returned as a one-cycle response.
//
// Ports
//   clk         in   1             clock
//   reset       in   1             synchronous active-high reset
//   req_valid   in   1             request present
//   req_ready   out  1             initiator idle; accept on valid & ready
//   req_op      in   4             4'h0 WR, 4'h1 RD, others forwarded unchanged
//   req_addr    in   N_ENTRY_BITS  entry index
//   req_wdat    in   32            write data (WR only)
//   rsp_valid   out  1             one-cycle response pulse
//   rsp_code    out  3             final status code (7 = poll timeout)
//   rsp_rdat    out  32            read data (RD with RDY), else 0
//   csr_addr    out  11            CSR address, held until ack
//   csr_wr_stb  out  1             one-cycle write strobe
//   csr_rd_stb  out  1             one-cycle read strobe
//   csr_wr_dat  out  32            CSR write data, held until ack
//   csr_ack     in   1             target acknowledge, >=1 cycle after strobe
//   csr_rd_dat  in   32            read data, valid with csr_ack after a read
// -----------------------------------------------------------------------------
module nx_indirect_access_initiator #(
    parameter logic [10:0] CMND_ADDRESS = 11'h454,
    parameter logic [10:0] STAT_ADDRESS = 11'h44C,
    parameter logic [10:0] DATA_ADDRESS = 11'h450,
    parameter int          N_ENTRY_BITS = 5,
    parameter int          POLL_MAX     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3:0]              req_op,
    input  logic [N_ENTRY_BITS-1:0] req_addr,
    input  logic [31:0]             req_wdat,
    output logic                    rsp_valid,
    output logic [2:0]              rsp_code,
    output logic [31:0]             rsp_rdat,
    output logic [10:0]             csr_addr,
    output logic                    csr_wr_stb,
    output logic                    csr_rd_stb,
    output logic [31:0]             csr_wr_dat,
    input  logic                    csr_ack,
    input  logic [31:0]             csr_rd_dat
);

    localparam int         CNT_W    = $clog2(POLL_MAX + 1);
    localparam logic [3:0] OP_WR    = 4'h0;
    localparam logic [3:0] OP_RD    = 4'h1;
    localparam logic [2:0] CODE_RDY = 3'd0;
    localparam logic [2:0] CODE_BSY = 3'd1;
    localparam logic [2:0] CODE_TMO = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_DATA = 3'd1,
        S_WR_CMND = 3'd2,
        S_POLL    = 3'd3,
        S_RD_DATA = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    // Command word: opcode in the top nibble, entry index in the low bits.
    function automatic logic [31:0] cmd_word(input logic [3:0]              op,
                                             input logic [N_ENTRY_BITS-1:0] idx);
        cmd_word = {op, 28'd0} | 32'(idx);
    endfunction

    state_t                  state_q, state_d;
    logic [3:0]              op_q, op_d;
    logic [N_ENTRY_BITS-1:0] addr_q, addr_d;
    logic [31:0]             wdat_q, wdat_d;
    logic [CNT_W-1:0]        poll_cnt_q, poll_cnt_d;
    logic                    outstanding_q, outstanding_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [2:0]              rsp_code_q, rsp_code_d;
    logic [31:0]             rsp_rdat_q, rsp_rdat_d;
    logic [10:0]             csr_addr_q, csr_addr_d;
    logic                    csr_wr_stb_q, csr_wr_stb_d;
    logic                    csr_rd_stb_q, csr_rd_stb_d;
    logic [31:0]             csr_wr_dat_q, csr_wr_dat_d;

    logic                    ack_ok_s;
    logic [2:0]              stat_code_s;
    logic [CNT_W-1:0]        poll_next_s;

    // An ack only counts while a strobe is outstanding and not in the strobe
    // cycle itself; this also drops acks that outlive a reset.
    assign ack_ok_s    = outstanding_q & csr_ack & ~csr_wr_stb_q & ~csr_rd_stb_q;
    assign stat_code_s = csr_rd_dat[31:29];
    // Saturating increment so the poll counter never wraps.
    assign poll_next_s = (poll_cnt_q == CNT_W'(POLL_MAX)) ? poll_cnt_q
                                                           : poll_cnt_q + CNT_W'(1);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            op_q          <= 4'h0;
            addr_q        <= '0;
            wdat_q        <= 32'h0;
            poll_cnt_q    <= '0;
            outstanding_q <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_code_q    <= 3'd0;
            rsp_rdat_q    <= 32'h0;
            csr_addr_q    <= 11'h0;
            csr_wr_stb_q  <= 1'b0;
            csr_rd_stb_q  <= 1'b0;
            csr_wr_dat_q  <= 32'h0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            wdat_q        <= wdat_d;
            poll_cnt_q    <= poll_cnt_d;
            outstanding_q <= outstanding_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_code_q    <= rsp_code_d;
            rsp_rdat_q    <= rsp_rdat_d;
            csr_addr_q    <= csr_addr_d;
            csr_wr_stb_q  <= csr_wr_stb_d;
            csr_rd_stb_q  <= csr_rd_stb_d;
            csr_wr_dat_q  <= csr_wr_dat_d;
        end
    end

    // Next-state logic for the access sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_op == OP_WR) begin
                        state_d = S_WR_DATA;
                    end else begin
                        state_d = S_WR_CMND;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_DATA: begin
                if (ack_ok_s) begin
                    state_d = S_WR_CMND;
                end else begin
                    state_d = S_WR_DATA;
                end
            end
            S_WR_CMND: begin
                if (ack_ok_s) begin
                    state_d = S_POLL;
                end else begin
                    state_d = S_WR_CMND;
                end
            end
            S_POLL: begin
                if (ack_ok_s) begin
                    if (stat_code_s == CODE_BSY) begin
                        if (poll_next_s < CNT_W'(POLL_MAX)) begin
                            state_d = S_POLL;
                        end else begin
                            state_d = S_RESP;
                        end
                    end else if ((stat_code_s == CODE_RDY) && (op_q == OP_RD)) begin
                        state_d = S_RD_DATA;
                    end else begin
                        state_d = S_RESP;
                    end
                end else begin
                    state_d = S_POLL;
                end
            end
            S_RD_DATA: begin
                if (ack_ok_s) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_RD_DATA;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values. Strobes are launched on the transition into
    // each bus phase (or re-poll) so they appear the cycle after accept/ack.
    always_comb begin
        op_d          = op_q;
        addr_d        = addr_q;
        wdat_d        = wdat_q;
        poll_cnt_d    = poll_cnt_q;
        outstanding_d = outstanding_q;
        rsp_valid_d   = 1'b0;
        rsp_code_d    = rsp_code_q;
        rsp_rdat_d    = rsp_rdat_q;
        csr_addr_d    = csr_addr_q;
        csr_wr_stb_d  = 1'b0;
        csr_rd_stb_d  = 1'b0;
        csr_wr_dat_d  = csr_wr_dat_q;
        req_ready_d   = (state_d == S_IDLE);

        if (ack_ok_s) begin
            outstanding_d = 1'b0;
        end else begin
            outstanding_d = outstanding_q;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d          = req_op;
                    addr_d        = req_addr;
                    wdat_d        = req_wdat;
                    rsp_rdat_d    = 32'h0;
                    outstanding_d = 1'b1;
                    csr_wr_stb_d  = 1'b1;
                    if (req_op == OP_WR) begin
                        csr_addr_d   = DATA_ADDRESS;
                        csr_wr_dat_d = req_wdat;
                    end else begin
                        csr_addr_d   = CMND_ADDRESS;
                        csr_wr_dat_d = cmd_word(req_op, req_addr);
                    end
                end else begin
                    outstanding_d = outstanding_q;
                end
            end
            S_WR_DATA: begin
                if (ack_ok_s) begin
                    outstanding_d = 1'b1;
                    csr_wr_stb_d  = 1'b1;
                    csr_addr_d    = CMND_ADDRESS;
                    csr_wr_dat_d  = cmd_word(op_q, addr_q);
                end else begin
                    csr_wr_stb_d  = 1'b0;
                end
            end
            S_WR_CMND: begin
                if (ack_ok_s) begin
                    poll_cnt_d    = '0;
                    outstanding_d = 1'b1;
                    csr_rd_stb_d  = 1'b1;
                    csr_addr_d    = STAT_ADDRESS;
                    csr_wr_dat_d  = 32'h0;
                end else begin
                    csr_rd_stb_d  = 1'b0;
                end
            end
            S_POLL: begin
                if (ack_ok_s) begin
                    poll_cnt_d = poll_next_s;
                    case (state_d)
                        S_POLL: begin
                            outstanding_d = 1'b1;
                            csr_rd_stb_d  = 1'b1;
                            csr_addr_d    = STAT_ADDRESS;
                        end
                        S_RD_DATA: begin
                            outstanding_d = 1'b1;
                            csr_rd_stb_d  = 1'b1;
                            csr_addr_d    = DATA_ADDRESS;
                        end
                        S_RESP: begin
                            rsp_valid_d = 1'b1;
                            if (stat_code_s == CODE_BSY) begin
                                rsp_code_d = CODE_TMO;
                            end else begin
                                rsp_code_d = stat_code_s;
                            end
                        end
                        default: begin
                            rsp_valid_d = 1'b0;
                        end
                    endcase
                end else begin
                    poll_cnt_d = poll_cnt_q;
                end
            end
            S_RD_DATA: begin
                if (ack_ok_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = CODE_RDY;
                    rsp_rdat_d  = csr_rd_dat;
                end else begin
                    rsp_valid_d = 1'b0;
                end
            end
            S_RESP: begin
                rsp_valid_d = 1'b0;
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_code   = rsp_code_q;
    assign rsp_rdat   = rsp_rdat_q;
    assign csr_addr   = csr_addr_q;
    assign csr_wr_stb = csr_wr_stb_q;
    assign csr_rd_stb = csr_rd_stb_q;
    assign csr_wr_dat = csr_wr_dat_q;

endmodule
